// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the Execute stage.
// Owns the HI/LO registers and raises busy while a multi-cycle operation runs.
// Optional build macro MDU_MADD_EN adds madd (MDop 101) and maddu (MDop 110).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no operation in flight; mthi/mtlo may write HI/LO directly
//   RUN   | operation in flight; counter counts down to the commit edge
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic        HIwrite,
  input  logic        LOwrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MSUB  = 3'b100;
  localparam logic [2:0] OP_MADD  = 3'b101;
  localparam logic [2:0] OP_MADDU = 3'b110;

  // Counter is loaded with N-1 so the commit lands on the N-th busy cycle.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  count;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;

  logic        op_valid, op_is_div;
  logic        accept, commit;

  logic [63:0] hilo, prod_u, prod_s, result;
  logic        result_en;
  logic [31:0] dvd, dvs, quo, rem, quo_s, rem_s;

  // Decode the incoming opcode: is it defined, and is it a divide.
  always_comb begin
    op_valid  = 1'b0;
    op_is_div = 1'b0;
    case (MDop)
      OP_MULTU, OP_MULT, OP_MSUB: op_valid = 1'b1;
      OP_DIVU, OP_DIV: begin
        op_valid  = 1'b1;
        op_is_div = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: op_valid = 1'b1;
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: accept a defined start in IDLE, commit at terminal count.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start && op_valid) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (count == 4'd0) begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // busy depends only on the state register, never on the operands.
  assign busy = (state == RUN);

  // Compute the commit value from the latched operands and the live HI/LO.
  always_comb begin
    hilo   = {HI, LO};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

    // Signed divide works on magnitudes so INT_MIN / -1 needs no special case.
    dvd = a_q;
    dvs = b_q;
    if (op_q == OP_DIV) begin
      dvd = a_q[31] ? (~a_q + 32'd1) : a_q;
      dvs = b_q[31] ? (~b_q + 32'd1) : b_q;
    end
    quo   = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    rem   = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
    quo_s = (a_q[31] ^ b_q[31]) ? (~quo + 32'd1) : quo;
    rem_s = a_q[31] ? (~rem + 32'd1) : rem;

    result    = hilo;
    result_en = 1'b1;
    case (op_q)
      OP_MULTU: result = prod_u;
      OP_MULT:  result = prod_s;
      OP_MSUB:  result = hilo - prod_s;
      OP_DIVU: begin
        result    = {rem, quo};
        result_en = (b_q != 32'd0);
      end
      OP_DIV: begin
        result    = {rem_s, quo_s};
        result_en = (b_q != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = hilo + prod_s;
      OP_MADDU: result = hilo + prod_u;
`endif
      default: begin
        result    = hilo;
        result_en = 1'b0;
      end
    endcase
  end

  // Datapath: operand latch, countdown, HI/LO commit and mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 3'd0;
      count <= 4'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= MDop;
        count <= op_is_div ? DIV_LOAD : MULT_LOAD;
      end else if (state == RUN && count != 4'd0) begin
        count <= count - 4'd1;
      end

      if (commit) begin
        if (result_en) begin
          HI <= result[63:32];
          LO <= result[31:0];
        end
      end else if (state == IDLE && !accept) begin
        if (HIwrite) HI <= A;
        if (LOwrite) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of single operations plus
// hand-written multi-cycle sequences, all checked through a result queue.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, HIwrite, LOwrite;
  logic [2:0]  MDop;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MDop(MDop),
    .HIwrite(HIwrite), .LOwrite(LOwrite), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        pre;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[12];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          inj_at;
  int          inj_kind;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: 64-bit longint arithmetic, including for div.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned pa, pb;
    logic [63:0]     acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    pa  = {32'd0, a};
    pb  = {32'd0, b};
    acc = {hi, lo};
    case (op)
      3'd0: return pa * pb;
      3'd1: return sa * sb;
      3'd2: return (b == 0) ? acc : {a % b, a / b};
      3'd3: begin
        if (b == 0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: return acc - (sa * sb);
`ifdef MDU_MADD_EN
      3'd5: return acc + (sa * sb);
      3'd6: return acc + (pa * pb);
`endif
      default: return acc;
    endcase
  endfunction

  function automatic int model_cyc(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd4: return MC;
      3'd2, 3'd3: return DC;
`ifdef MDU_MADD_EN
      3'd5, 3'd6: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic preload(input logic [31:0] hi, input logic [31:0] lo);
    HIwrite = 1'b1; A = hi;
    tick();
    HIwrite = 1'b0; LOwrite = 1'b1; A = lo;
    tick();
    LOwrite = 1'b0;
    m_hi = hi;
    m_lo = lo;
  endtask

  // Drive one start across edge t and queue its expected outcome.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                       input logic also_wr);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.cyc = ecyc;
    sb.push_back(e);
    start = 1'b1; MDop = op; A = a; B = b;
    HIwrite = also_wr; LOwrite = also_wr;
    tick();
    start = 1'b0; HIwrite = 1'b0; LOwrite = 1'b0;
  endtask

  // Count busy cycles, confirm HI/LO hold meanwhile, then compare the commit.
  task automatic collect(input string name, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      check({name, "_hold_hi"}, HI, hold_hi);
      check({name, "_hold_lo"}, LO, hold_lo);
      if (cyc == inj_at && inj_kind == 1) begin
        start = 1'b1; MDop = 3'b010; A = 32'd100; B = 32'd5;
      end
      if (cyc == inj_at && inj_kind == 2) begin
        HIwrite = 1'b1; A = 32'h1234;
      end
      tick();
      start = 1'b0; HIwrite = 1'b0; LOwrite = 1'b0;
    end
    inj_at = 0;
    inj_kind = 0;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_queue: got empty expected entry", name);
    end else begin
      e = sb.pop_front();
      check({name, "_cycles"}, 32'(cyc), 32'(e.cyc));
      check({name, "_hi"}, HI, e.hi);
      check({name, "_lo"}, LO, e.lo);
      check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDop = 3'd0; HIwrite = 1'b0; LOwrite = 1'b0;
    A = 32'd0; B = 32'd0; inj_at = 0; inj_kind = 0;

    tbl[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    tbl[1]  = '{3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'd0, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3]  = '{3'd4, 32'd3, 32'd4, 1'b1, 32'd0, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    tbl[4]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFE, 32'h00000001, MC};
    tbl[5]  = '{3'd2, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 32'd2, 32'd14, DC};
    tbl[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 32'd0, 32'h80000000, DC};
    tbl[7]  = '{3'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFD, DC};
`ifdef MDU_MADD_EN
    tbl[8]  = '{3'd6, 32'd1, 32'd1, 1'b1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, MC};
    tbl[9]  = '{3'd5, 32'hFFFFFFFF, 32'd3, 1'b1, 32'd0, 32'd5, 32'd0, 32'd2, MC};
`else
    tbl[8]  = '{3'd6, 32'd1, 32'd1, 1'b1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 0};
    tbl[9]  = '{3'd5, 32'hFFFFFFFF, 32'd3, 1'b1, 32'd0, 32'd5, 32'd0, 32'd5, 0};
`endif
    tbl[10] = '{3'd7, 32'd9, 32'd9, 1'b1, 32'd1, 32'd2, 32'd1, 32'd2, 0};
    tbl[11] = '{3'd2, 32'd9, 32'd0, 1'b1, 32'd3, 32'd4, 32'd3, 32'd4, DC};

    tick(); tick();
    reset = 1'b0;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Reset with nonzero HI/LO held for two cycles.
    preload(32'hAAAA, 32'h5555);
    check("mthi_vis", HI, 32'hAAAA);
    check("mtlo_vis", LO, 32'h5555);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("rst2_hi", HI, 32'd0);
    check("rst2_lo", LO, 32'd0);
    check("rst2_busy", {31'd0, busy}, 32'd0);

    // Both write enables in IDLE.
    HIwrite = 1'b1; LOwrite = 1'b1; A = 32'hCAFE;
    tick();
    HIwrite = 1'b0; LOwrite = 1'b0;
    check("both_hi", HI, 32'hCAFE);
    check("both_lo", LO, 32'hCAFE);
    m_hi = 32'hCAFE; m_lo = 32'hCAFE;

    // Table of single operations.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].pre) preload(tbl[i].pre_hi, tbl[i].pre_lo);
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo, tbl[i].exp_cyc, 1'b0);
      collect($sformatf("vec%0d", i), m_hi, m_lo);
    end

    // Random operations against the longint reference.
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [63:0] r;
      op = 3'($urandom_range(0, 4));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50)));
      r  = model(op, a, b, m_hi, m_lo);
      issue(op, a, b, r[63:32], r[31:0], model_cyc(op), 1'b0);
      collect($sformatf("rnd%0d", i), m_hi, m_lo);
    end

    // msub with an mthi pulse mid-busy: HI must not take the write.
    preload(32'd0, 32'd10);
    inj_at = 2; inj_kind = 2;
    issue(3'd4, 32'd3, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFE, MC, 1'b0);
    collect("msub_mthi", 32'd0, 32'd10);

    // Second start on busy cycle 2 is ignored; multu keeps original operands.
    inj_at = 2; inj_kind = 1;
    issue(3'd0, 32'd7, 32'd9, 32'd0, 32'd63, MC, 1'b0);
    collect("start_busy", m_hi, m_lo);

    // mthi/mtlo in the same cycle as an accepted start lose to start.
    issue(3'd0, 32'd2, 32'd3, 32'd0, 32'd6, MC, 1'b1);
    collect("start_prio", m_hi, m_lo);

    // Reset mid-operation aborts it without a later commit.
    preload(32'd7, 32'd8);
    start = 1'b1; MDop = 3'd1; A = 32'd5; B = 32'd5;
    tick();
    start = 1'b0;
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);
    check("abort_late_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
